// File: rtl/bus8_arb_rr_x2.sv
// Two-master round-robin arbiter and single-command sequencer for the 8-bit register bus.
// Define BUS8_ARB_TIMEOUT_EN to abort reads that never see i_Bus_Rd_DV (flagged on o_Mx_Err).
module bus8_arb_rr_x2 #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic              i_Bus_Rst_L,
   input  logic              i_Bus_Clk,
   input  logic              i_M0_Req,
   input  logic              i_M0_Wr_Rd_n,
   input  logic [ADDR_W-1:0] i_M0_Addr,
   input  logic [7:0]        i_M0_Wr_Data,
   output logic              o_M0_Ack,
   output logic [7:0]        o_M0_Rd_Data,
   output logic              o_M0_Err,
   input  logic              i_M1_Req,
   input  logic              i_M1_Wr_Rd_n,
   input  logic [ADDR_W-1:0] i_M1_Addr,
   input  logic [7:0]        i_M1_Wr_Data,
   output logic              o_M1_Ack,
   output logic [7:0]        o_M1_Rd_Data,
   output logic              o_M1_Err,
   output logic              o_Bus_CS,
   output logic              o_Bus_Wr_Rd_n,
   output logic [ADDR_W-1:0] o_Bus_Addr,
   output logic [7:0]        o_Bus_Wr_Data,
   input  logic [7:0]        i_Bus_Rd_Data,
   input  logic              i_Bus_Rd_DV
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;     // 1: M1 was granted last
   logic              gnt_q, gnt_d;       // owner of the transaction in flight
   logic              cs_q, cs_d;
   logic              wr_rd_n_q, wr_rd_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic [7:0]        rd0_q, rd0_d, rd1_q, rd1_d;

   logic              req0_v, req1_v, sel;
   logic              done, done_rd;
   logic [7:0]        done_data;

`ifdef BUS8_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]        cnt_q, cnt_d;
   logic              err0_q, err0_d, err1_q, err1_d;
   logic              done_err;
`endif

   // A master's Req during its own Ack cycle is the tail of the finished transaction.
   assign req0_v = i_M0_Req & ~ack0_q;
   assign req1_v = i_M1_Req & ~ack1_q;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      cs_d      = 1'b0;
      wr_rd_n_d = wr_rd_n_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rd0_d     = rd0_q;
      rd1_d     = rd1_q;
      sel       = 1'b0;
      done      = 1'b0;
      done_rd   = 1'b0;
      done_data = '0;
`ifdef BUS8_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err0_d    = 1'b0;
      err1_d    = 1'b0;
      done_err  = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req0_v | req1_v) begin
               sel     = (req0_v & req1_v) ? ~last_q : req1_v;
               gnt_d   = sel;
               last_d  = sel;
               cs_d    = 1'b1;
               state_d = ST_ISSUE;
               if (sel) begin
                  wr_rd_n_d = i_M1_Wr_Rd_n;
                  addr_d    = i_M1_Addr;
                  wr_data_d = i_M1_Wr_Data;
               end else begin
                  wr_rd_n_d = i_M0_Wr_Rd_n;
                  addr_d    = i_M0_Addr;
                  wr_data_d = i_M0_Wr_Data;
               end
            end
         end
         ST_ISSUE: begin
            if (wr_rd_n_q) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_RD;
`ifdef BUS8_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_WAIT_RD: begin
            if (i_Bus_Rd_DV) begin
               done      = 1'b1;
               done_rd   = 1'b1;
               done_data = i_Bus_Rd_Data;
               state_d   = ST_IDLE;
            end
`ifdef BUS8_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               done      = 1'b1;
               done_rd   = 1'b1;
               done_err  = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (done) begin
         if (gnt_q) begin
            ack1_d = 1'b1;
            if (done_rd) rd1_d = done_data;
`ifdef BUS8_ARB_TIMEOUT_EN
            err1_d = done_err;
`endif
         end else begin
            ack0_d = 1'b1;
            if (done_rd) rd0_d = done_data;
`ifdef BUS8_ARB_TIMEOUT_EN
            err0_d = done_err;
`endif
         end
      end
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         cs_q      <= 1'b0;
         wr_rd_n_q <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rd0_q     <= '0;
         rd1_q     <= '0;
`ifdef BUS8_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         cs_q      <= cs_d;
         wr_rd_n_q <= wr_rd_n_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
`ifdef BUS8_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
`endif
      end
   end

   assign o_Bus_CS      = cs_q;
   assign o_Bus_Wr_Rd_n = wr_rd_n_q;
   assign o_Bus_Addr    = addr_q;
   assign o_Bus_Wr_Data = wr_data_q;
   assign o_M0_Ack      = ack0_q;
   assign o_M1_Ack      = ack1_q;
   assign o_M0_Rd_Data  = rd0_q;
   assign o_M1_Rd_Data  = rd1_q;
`ifdef BUS8_ARB_TIMEOUT_EN
   assign o_M0_Err      = err0_q;
   assign o_M1_Err      = err1_q;
`else
   assign o_M0_Err      = 1'b0;
   assign o_M1_Err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus8_arb_rr_x2.sv
// Directed bench for bus8_arb_rr_x2: writes, reads, fairness, read timeout, spurious DV and reset abort.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus8_arb_rr_x2;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       m0_req, m0_wr, m0_ack, m0_err, m1_req, m1_wr, m1_ack, m1_err;
   logic [7:0] m0_addr, m0_wd, m0_rd, m1_addr, m1_wd, m1_rd;
   logic       bus_cs, bus_wr, bus_dv;
   logic [7:0] bus_addr, bus_wd, bus_rd;

   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;
   int unsigned n_ack;

   always #5 clk = ~clk;

   bus8_arb_rr_x2 #(.ADDR_W(8), .TIMEOUT_CYCLES(15)) dut (
      .i_Bus_Rst_L  (rst_l),
      .i_Bus_Clk    (clk),
      .i_M0_Req     (m0_req),
      .i_M0_Wr_Rd_n (m0_wr),
      .i_M0_Addr    (m0_addr),
      .i_M0_Wr_Data (m0_wd),
      .o_M0_Ack     (m0_ack),
      .o_M0_Rd_Data (m0_rd),
      .o_M0_Err     (m0_err),
      .i_M1_Req     (m1_req),
      .i_M1_Wr_Rd_n (m1_wr),
      .i_M1_Addr    (m1_addr),
      .i_M1_Wr_Data (m1_wd),
      .o_M1_Ack     (m1_ack),
      .o_M1_Rd_Data (m1_rd),
      .o_M1_Err     (m1_err),
      .o_Bus_CS     (bus_cs),
      .o_Bus_Wr_Rd_n(bus_wr),
      .o_Bus_Addr   (bus_addr),
      .o_Bus_Wr_Data(bus_wd),
      .i_Bus_Rd_Data(bus_rd),
      .i_Bus_Rd_DV  (bus_dv)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [37:0] all_outs();
      return {bus_cs, bus_wr, bus_addr, bus_wd, m0_ack, m1_ack, m0_err, m1_err, m0_rd, m1_rd};
   endfunction

   initial begin
      rst_l = 1'b0;
      m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wd = '0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wd = '0;
      bus_dv = 1'b0; bus_rd = '0;
      repeat (3) @(negedge clk);
      check("reset_outs", 64'(all_outs()), 64'd0);
      rst_l = 1'b1;
      @(negedge clk);

      // M0 write 02/A5; inputs scrambled and a stray DV after the grant edge
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h02; m0_wd = 8'hA5;
      @(negedge clk);
      check("wr_cmd", {bus_cs, bus_wr, bus_addr, bus_wd, m0_ack}, {1'b1, 1'b1, 8'h02, 8'hA5, 1'b0});
      m0_addr = 8'hFF; m0_wd = 8'h00; m0_wr = 1'b0;
      bus_dv = 1'b1; bus_rd = 8'h77;
      @(negedge clk);
      check("wr_ack", {bus_cs, m0_ack, m1_ack, m0_err, m0_rd}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      m0_req = 1'b0; bus_dv = 1'b0;
      @(negedge clk);
      check("wr_after", {bus_cs, m0_ack, bus_wr, bus_addr, bus_wd}, {1'b0, 1'b0, 1'b1, 8'h02, 8'hA5});

      // M1 read 01, slave DV one cycle after CS with 3C
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h01;
      @(negedge clk);
      check("rd_cmd", {bus_cs, bus_wr, bus_addr}, {1'b1, 1'b0, 8'h01});
      @(negedge clk);
      check("rd_wait", {bus_cs, m1_ack}, {1'b0, 1'b0});
      bus_dv = 1'b1; bus_rd = 8'h3C;
      @(negedge clk);
      check("rd_ack", {m1_ack, m1_rd, m1_err, m0_ack}, {1'b1, 8'h3C, 1'b0, 1'b0});
      m1_req = 1'b0; bus_dv = 1'b0; bus_rd = 8'h00;
      @(negedge clk);
      check("rd_hold", {m1_ack, m1_rd}, {1'b0, 8'h3C});

      // Stray DV while idle
      bus_dv = 1'b1; bus_rd = 8'h99;
      @(negedge clk);
      check("idle_dv", {m0_ack, m1_ack, m0_rd, m1_rd}, {1'b0, 1'b0, 8'h00, 8'h3C});
      bus_dv = 1'b0;

      // Fairness from reset with both masters requesting continuously
      rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h10; m0_wd = 8'h11;
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h20; m1_wd = 8'h22;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("fair_cs%0d", i), 64'(bus_cs), 64'((i % 2) == 0));
         if ((i % 2) == 0)
            check($sformatf("fair_addr%0d", i), 64'(bus_addr), ((i % 4) == 0) ? 64'h10 : 64'h20);
         check($sformatf("fair_ack%0d", i), {m0_ack, m1_ack}, {(i % 4) == 1, (i % 4) == 3});
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      check("fair_quiet", {bus_cs, m0_ack, m1_ack}, 3'b000);

      // M0 read returning 5A, then a read the slave never answers
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h05;
      @(negedge clk);
      @(negedge clk);
      bus_dv = 1'b1; bus_rd = 8'h5A;
      @(negedge clk);
      check("m0_rd_ack", {m0_ack, m0_rd, m0_err}, {1'b1, 8'h5A, 1'b0});
      m0_req = 1'b0; bus_dv = 1'b0;
      @(negedge clk);
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h06;
      n_ack = 0;
`ifdef BUS8_ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (m0_ack) n_ack++;
      end
      check("to_early", 64'(n_ack), 64'd0);
      @(negedge clk);
      check("to_ack", {m0_ack, m0_err, m0_rd, m1_ack}, {1'b1, 1'b1, 8'h00, 1'b0});
      m0_req = 1'b0;
      @(negedge clk);
      check("to_clear", {m0_ack, m0_err}, 2'b00);
`else
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m0_ack || m0_err) n_ack++;
      end
      check("no_to_ack", 64'(n_ack), 64'd0);
      bus_dv = 1'b1; bus_rd = 8'h66;
      @(negedge clk);
      check("late_rd_ack", {m0_ack, m0_err, m0_rd}, {1'b1, 1'b0, 8'h66});
      m0_req = 1'b0; bus_dv = 1'b0;
      @(negedge clk);
`endif
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h08; m0_wd = 8'h33;
      @(negedge clk);
      check("next_cmd", {bus_cs, bus_wr, bus_addr, bus_wd}, {1'b1, 1'b1, 8'h08, 8'h33});
      @(negedge clk);
      check("next_ack", {m0_ack, m0_err}, 2'b10);
      m0_req = 1'b0;
      @(negedge clk);

      // Reset while M1 read sits in WAIT_RD
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h07;
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      check("rst_async", 64'(all_outs()), 64'd0);
      m1_req = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      bus_dv = 1'b1; bus_rd = 8'hEE;
      @(negedge clk);
      check("late_dv", {m0_ack, m1_ack, m1_rd}, {1'b0, 1'b0, 8'h00});
      bus_dv = 1'b0;
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h30; m1_wd = 8'h44;
      @(negedge clk);
      check("m1_first", {bus_cs, bus_addr, bus_wd}, {1'b1, 8'h30, 8'h44});
      @(negedge clk);
      check("m1_ack", {m1_ack, m0_ack}, 2'b10);
      m1_req = 1'b0;
      @(negedge clk);
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h40; m0_wd = 8'h55;
      m1_req = 1'b1;
      @(negedge clk);
      check("rr_after_m1", {bus_cs, bus_addr}, {1'b1, 8'h40});
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/bus8_arb_rr_x2.md
Name: bus8_arb_rr_x2

Overview:
- Two-master round-robin arbiter and transaction sequencer for the 8-bit FPGA register bus.
- Each master posts one read or write at a time through a Req/Ack handshake.
- The block grants one master, drives a single-cycle bus command to the register slaves, and returns completion (plus read data) to the granted master.
- Sits between masters (UART command decoder, sequencer FSM) and the shared register-block bus.

Parameters:
ADDR_W, 8, width of the bus address carried from master to slave bus.
TIMEOUT_CYCLES, 15, cycles to wait in WAIT_RD for i_Bus_Rd_DV before aborting (used only with the optional feature); legal range 1..255.

Ports:
i_Bus_Rst_L  in  1  async active-low reset
i_Bus_Clk  in  1  clock; all logic rising-edge
i_M0_Req  in  1  master 0 request; level, held until o_M0_Ack
i_M0_Wr_Rd_n  in  1  1 = write, 0 = read
i_M0_Addr  in  ADDR_W  transaction address
i_M0_Wr_Data  in  8  write data
o_M0_Ack  out  1  one-cycle completion pulse
o_M0_Rd_Data  out  8  read data, valid while o_M0_Ack = 1
o_M0_Err  out  1  one-cycle read-timeout flag, coincident with o_M0_Ack
i_M1_*, o_M1_*  same set as M0, for master 1
o_Bus_CS  out  1  slave chip select, one-cycle pulse
o_Bus_Wr_Rd_n  out  1  command direction
o_Bus_Addr  out  ADDR_W  command address
o_Bus_Wr_Data  out  8  command write data
i_Bus_Rd_Data  in  8  slave read data
i_Bus_Rd_DV  in  1  slave read data valid, one-cycle pulse

Behaviour:
- Reset: i_Bus_Rst_L, asynchronous, active-low; clock i_Bus_Clk.
  - While reset is low, all outputs are 0, state = IDLE, and the round-robin pointer favours M0.
  - Reset asserted mid-transaction aborts it immediately; no Ack is issued.
- State IDLE: evaluated each cycle.
  - Exactly one Req high: that master is granted.
  - Both Req high: the master not granted last is granted; the pointer updates on every grant.
  - At the grant edge, latch that master's Wr_Rd_n/Addr/Wr_Data into the o_Bus_* registers, set o_Bus_CS = 1, and go to ISSUE.
- State ISSUE: o_Bus_CS is high for exactly this one cycle.
  - Write: at the next edge pulse the granted o_Mx_Ack for one cycle and return to IDLE. Ack is 2 cycles after the IDLE cycle that saw Req.
  - Read: go to WAIT_RD.
- State WAIT_RD: on i_Bus_Rd_DV = 1, register i_Bus_Rd_Data into o_Mx_Rd_Data and pulse o_Mx_Ack for one cycle, then return to IDLE.
  - With a slave DV 1 cycle after CS, read Ack arrives 3 cycles after Req is seen.
- Data and bus hold rules:
  - o_Mx_Rd_Data holds its last value outside Ack.
  - o_Bus_Addr, o_Bus_Wr_Rd_n and o_Bus_Wr_Data hold their last values after CS drops.
- Master protocol: a master must drop Req in the cycle after it sees Ack. A Req still high in the IDLE cycle following Ack is a new transaction.
- The non-granted master's Req and inputs are ignored until it is granted; its request is never lost while held.
- i_Bus_Rd_DV is ignored outside WAIT_RD, including during a write.
- Fairness: with both masters requesting continuously, grants alternate M0, M1, M0, …; there are no back-to-back grants to one master while the other waits.
- Changes to Req or inputs after the grant edge do not affect the transaction in flight.

Optional Feature:
BUS8_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to WAIT_RD and increments each WAIT_RD cycle without DV.
  - When it reaches TIMEOUT_CYCLES, the block pulses o_Mx_Ack and o_Mx_Err together, drives o_Mx_Rd_Data = 8'h00, and returns to IDLE.
  - DV in the same cycle as the timeout wins: normal Ack, no Err.
- Undefined: no counter; WAIT_RD waits indefinitely for DV; o_M0_Err and o_M1_Err are tied 0.

Test Plan:
- Reset release, M0 write Addr=8'h02 Data=8'hA5 → o_Bus_CS one cycle with Addr 02, Wr_Rd_n 1, Data A5; o_M0_Ack 2 cycles after Req is seen; o_M1_Ack stays 0.
- M1 read Addr=8'h01, slave model returns 8'h3C one cycle after CS → o_M1_Ack one cycle with o_M1_Rd_Data=3C, o_M1_Err=0.
- M0 and M1 Req asserted in the same cycle after reset, both held (re-requesting after each Ack) → grant order M0, M1, M0, M1 across 4 transactions; never two CS in consecutive cycles.
- Read with no DV, macro defined, TIMEOUT_CYCLES=15 → o_M0_Ack and o_M0_Err both pulse after 15 WAIT_RD cycles, Rd_Data=00; next request is served normally. Macro undefined → no Ack after 100 cycles.
- Spurious i_Bus_Rd_DV during IDLE and during a write → no Ack, no Rd_Data change.
- Reset pulse while in WAIT_RD → all outputs 0 immediately; late DV after reset release produces no Ack; next M1 request granted first only if M0 is idle.
